// File: rtl/bcd_adder_serial_pkg.sv
// Shared constants and FSM encoding for the digit-serial packed-BCD adder.
package bcd_pkg;
  localparam int                 DIGIT_W  = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Nines complement taken mod 16 so non-BCD digits stay deterministic.
  function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(BCD_MAX - d);
  endfunction
endpackage

// File: rtl/bcd_adder_serial_if.sv
// Operand/result handshake bundle for bcd_adder_serial.
// Optional BCD_SUB_EN adds the 'sub' operation select.
interface bcd_adder_serial_if #(parameter int DIGITS = 4) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  cin;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport slave (
    input  in_valid, A, B, cin, out_ready,
`ifdef BCD_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout, err
  );

  modport master (
    output in_valid, A, B, cin, out_ready,
`ifdef BCD_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_slice.sv
// Combinational single-digit BCD adder: a + b + c with +6 decimal correction.
module bcd_digit_slice
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_c,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_c,
  output logic               o_invalid
);
  logic [DIGIT_W:0] w_s;

  always_comb begin
    w_s = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_c};
    if (w_s > {1'b0, BCD_MAX}) begin
      o_digit = DIGIT_W'(w_s + {1'b0, BCD_CORR});
      o_c     = 1'b1;
    end else begin
      o_digit = w_s[DIGIT_W-1:0];
      o_c     = 1'b0;
    end
    o_invalid = (i_a > BCD_MAX) | (i_b > BCD_MAX);
  end
endmodule

// File: rtl/bcd_adder_serial.sv
// Multi-digit packed-BCD adder, one digit per clock LSD first through one slice.
// Define BCD_SUB_EN to add subtraction (A - B - borrow) via nines complement.
module bcd_adder_serial
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CNT_W  = $clog2(DIGITS + 1),
  localparam int W      = 4 * DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_adder_serial_if.slave     bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t             r_state;
  logic [W-1:0]       r_a, r_b, r_sum;
  logic               r_c, r_cout, r_err, r_in_ready, r_out_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] w_b_eff, w_digit;
  logic               w_c, w_inv, w_c_init;

`ifdef BCD_SUB_EN
  logic r_sub;
  // Nines complement maps 10..15 onto 15..10, so the slice's invalid flag
  // still reflects the original B digit.
  assign w_b_eff  = r_sub ? nines(r_b[DIGIT_W-1:0]) : r_b[DIGIT_W-1:0];
  assign w_c_init = bus.sub ? ~bus.cin : bus.cin;
`else
  assign w_b_eff  = r_b[DIGIT_W-1:0];
  assign w_c_init = bus.cin;
`endif

  bcd_digit_slice u_slice (
    .i_a       (r_a[DIGIT_W-1:0]),
    .i_b       (w_b_eff),
    .i_c       (r_c),
    .o_digit   (w_digit),
    .o_c       (w_c),
    .o_invalid (w_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
`ifdef BCD_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_c        <= w_c_init;
`ifdef BCD_SUB_EN
            r_sub      <= bus.sub;
`endif
            r_sum      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // Operands shift down so the slice always sees digit 0.
          r_a   <= r_a >> DIGIT_W;
          r_b   <= r_b >> DIGIT_W;
          r_c   <= w_c;
          r_err <= r_err | w_inv;
          r_cnt <= r_cnt + CNT_W'(1);
          for (int k = 0; k < DIGITS; k++)
            if (r_cnt == CNT_W'(k)) r_sum[DIGIT_W*k +: DIGIT_W] <= w_digit;
          if (r_cnt == LAST) begin
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.err       = r_err;
endmodule

// File: doc/bcd_adder_serial.md
Name: bcd_adder_serial

Overview:
Parametrised multi-digit packed-BCD adder that processes one decimal digit per clock, least-significant first, through a single shared digit-adder slice. It extends the existing single-digit combinational BCD adder to N digits, with valid/ready handshakes on both sides, a registered result and detection of non-BCD input digits. It sits between operand registers and result consumers in the decimal datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.
CNT_W, $clog2(DIGITS+1), digit-counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  operands present.
in_ready  output  1  block can accept operands.
A  input  4*DIGITS  packed BCD operand A; digit 0 = bits [3:0].
B  input  4*DIGITS  packed BCD operand B.
cin  input  1  decimal carry-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  4*DIGITS  packed BCD result.
cout  output  1  decimal carry-out of the most-significant digit.
err  output  1  at least one input digit of A or B was >9.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; err=0; counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch A, B and cin into shift/carry registers; clear sum, err and counter; go to RUN.
- RUN: in_ready=0. Each cycle, digit k (k = counter) is added: s = a_k + b_k + c (5-bit). If s>9: digit = (s+6) mod 16, c' = 1; else digit = s, c' = 0. Store the digit at sum[4k+3:4k], update the carry, counter++. err |= (a_k>9)|(b_k>9). After digit DIGITS-1: cout = final carry; go to DONE.
- Latency: out_valid rises exactly DIGITS clock edges after the accepting edge.
- DONE: out_valid=1; sum, cout and err are held stable. On out_ready=1: out_valid=0 and the FSM goes to IDLE. in_ready remains 0, so a new operand cannot be accepted in the same cycle the result leaves. Throughput is one operation per DIGITS+2 cycles.
- The digit rule applies unchanged to non-BCD inputs, so results stay deterministic. For example, 15+15+1 gives s=31, digit 5, carry 1.
- Inputs are ignored outside the accepting edge. Changes to A, B or cin during RUN do not affect the result.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight result is discarded.
- sum is registered only; there is no combinational path from inputs to outputs.
- DIGITS=1: RUN lasts 1 cycle, and the result equals the single-digit adder's output.

Optional Feature:
BCD_SUB_EN: adds input port `sub` (1 bit), which is latched at acceptance.
- With sub=1, operand B digits are replaced by their nines complement (9-b_k, computed mod 16), and the effective carry-in is ~cin, where cin acts as borrow-in. Result = A − B − cin.
- cout=1 means no borrow, and sum is the true difference.
- cout=0 means negative, and sum is the ten's complement 10^DIGITS + (A−B−cin).
- err is evaluated on the original B.
Without the macro, the `sub` port does not exist and the block adds only.

Decomposition:
- Package bcd_pkg: digit width constant (4), BCD_MAX=9, correction constant 6, and the FSM state enum (IDLE/RUN/DONE).
- Sub-module bcd_digit_slice: combinational single-digit adder (a, b, c → digit, c', invalid). It is instantiated once and reused serially; it is also used by the bench as a golden model.

Test Plan:
1. DIGITS=4: A=0x1234, B=0x5678, cin=0 → sum=0x6912, cout=0, err=0, out_valid exactly 4 edges after acceptance.
2. A=0x9999, B=0x0001, cin=0 → sum=0x0000, cout=1. A=0x9999, B=0x9999, cin=1 → sum=0x9999, cout=1.
3. Backpressure: hold out_ready=0 for 5 cycles after the result → sum and cout stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → out_valid falls the next edge, then in_ready=1.
4. Assert rst for 1 cycle during RUN (after 2 digits) → all outputs return to reset values asynchronously, in_ready=1. A fresh 0x0005+0x0005 then gives 0x0010, cout=0.
5. A=0x00A0, B=0x0001 → err=1, sum=0x0101 (digit1: 10+0 → 0 carry 1). Also sweep all 10x10x2 single-digit combinations at DIGITS=1 against bcd_digit_slice.
6. With BCD_SUB_EN: 0x0500−0x0123, cin=0 → sum=0x0377, cout=1. 0x0100−0x0200 → sum=0x9900, cout=0.
